// File: rtl/dmem_lsu_requester_if.sv
// Load/store request, writeback response and dataMem port bundle for dmem_lsu_requester.
// The requester uses the master modport: it masters the dataMem port and answers
// the execute/writeback side. The environment (execute stage, writeback, dataMem)
// uses the slave modport.
interface dmem_lsu_requester_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 64
);
    // execute -> LSU request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    // LSU -> writeback response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    // LSU <-> dataMem
    logic [INST_W-1:0] Single_Instruction;
    logic [ADDR_W-1:0] address;
    logic [31:0]       storeData;
    logic [31:0]       loadData_w;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  rsp_ready, loadData_w,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Single_Instruction, address, storeData
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output rsp_ready, loadData_w,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Single_Instruction, address, storeData
    );
endinterface

// File: rtl/dmem_lsu_requester.sv
// Requester-side load/store unit: one request at a time, translated into the
// one-hot dataMem Single_Instruction code, with the load result returned on a
// valid/ready response channel.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned halfword/word accesses
// with rsp_err instead of issuing them to dataMem.
module dmem_lsu_requester #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INST_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_lsu_requester_if.master  bus
);
    localparam int unsigned CNT_W = 3;

    // One-hot positions matching the dataMem instruction encoding
    localparam logic [INST_W-1:0] INST_LB  = INST_W'(64'h1) << 10;
    localparam logic [INST_W-1:0] INST_LH  = INST_W'(64'h1) << 11;
    localparam logic [INST_W-1:0] INST_LW  = INST_W'(64'h1) << 12;
    localparam logic [INST_W-1:0] INST_LBU = INST_W'(64'h1) << 13;
    localparam logic [INST_W-1:0] INST_LHU = INST_W'(64'h1) << 14;
    localparam logic [INST_W-1:0] INST_SB  = INST_W'(64'h1) << 15;
    localparam logic [INST_W-1:0] INST_SH  = INST_W'(64'h1) << 16;
    localparam logic [INST_W-1:0] INST_SW  = INST_W'(64'h1) << 17;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] address_q;
    logic [31:0]       store_data_q;
    logic              store_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [INST_W-1:0] inst_code_c;
    logic              legal_c;
    logic              misalign_c;

    // Map store flag + funct3 to the dataMem op code; unmapped combinations are illegal
    always_comb begin
        inst_code_c = '0;
        legal_c     = 1'b1;
        case ({bus.req_store, bus.req_funct3})
            4'b0_000: inst_code_c = INST_LB;
            4'b0_001: inst_code_c = INST_LH;
            4'b0_010: inst_code_c = INST_LW;
            4'b0_100: inst_code_c = INST_LBU;
            4'b0_101: inst_code_c = INST_LHU;
            4'b1_000: inst_code_c = INST_SB;
            4'b1_001: inst_code_c = INST_SH;
            4'b1_010: inst_code_c = INST_SW;
            default:  legal_c     = 1'b0;
        endcase
    end

    // Alignment check on the incoming request (halfword: bit 0, word: bits 1:0)
    always_comb begin
        misalign_c = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (bus.req_funct3[1:0] == 2'd1)
            misalign_c = bus.req_addr[0];
        else if (bus.req_funct3[1:0] == 2'd2)
            misalign_c = (bus.req_addr[1:0] != 2'd0);
`endif
    end

    // Request/issue/wait/response sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            inst_q       <= '0;
            address_q    <= '0;
            store_data_q <= '0;
            store_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (!legal_c || misalign_c) begin
                            // rejected requests never touch dataMem
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q      <= ISSUE;
                            inst_q       <= inst_code_c;
                            address_q    <= bus.req_addr;
                            store_data_q <= bus.req_wdata;
                            store_q      <= bus.req_store;
                        end
                    end
                end
                ISSUE: begin
                    inst_q <= '0;
                    if (store_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= bus.loadData_w;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    inst_q      <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready          = req_ready_q;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_rdata          = rsp_rdata_q;
    assign bus.rsp_err            = rsp_err_q;
    assign bus.Single_Instruction = inst_q;
    assign bus.address            = address_q;
    assign bus.storeData          = store_data_q;
endmodule

// File: tb/tb_dmem_lsu_requester.sv
// Directed bench for dmem_lsu_requester: a byte-addressed dataMem model on a
// MEM_LAT=1 instance, plus a MEM_LAT=4 instance for latency and mid-WAIT reset.
module tb_dmem_lsu_requester;
    localparam logic [63:0] INST_LB  = 64'h0000_0000_0000_0400;
    localparam logic [63:0] INST_LH  = 64'h0000_0000_0000_0800;
    localparam logic [63:0] INST_LW  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] INST_LBU = 64'h0000_0000_0000_2000;
    localparam logic [63:0] INST_LHU = 64'h0000_0000_0000_4000;
    localparam logic [63:0] INST_SB  = 64'h0000_0000_0000_8000;
    localparam logic [63:0] INST_SH  = 64'h0000_0000_0001_0000;
    localparam logic [63:0] INST_SW  = 64'h0000_0000_0002_0000;
    localparam logic [31:0] JUNK     = 32'hA5A5_A5A5;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset1;
    logic reset4;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_lsu_requester_if #(.ADDR_W(32), .INST_W(64)) bus1 ();
    dmem_lsu_requester_if #(.ADDR_W(32), .INST_W(64)) bus4 ();

    dmem_lsu_requester #(.MEM_LAT(1), .ADDR_W(32), .INST_W(64)) u_dut1 (
        .clk(clk), .reset(reset1), .bus(bus1)
    );
    dmem_lsu_requester #(.MEM_LAT(4), .ADDR_W(32), .INST_W(64)) u_dut4 (
        .clk(clk), .reset(reset4), .bus(bus4)
    );

    // dataMem model for the MEM_LAT=1 instance: little-endian bytes, sign/zero extension
    logic [7:0]  mem [0:255];
    logic [31:0] ld1;
    logic [7:0]  ma;
    assign ma = bus1.address[7:0];
    assign bus1.loadData_w = ld1;

    always @(posedge clk) begin
        if (!reset1) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[4] <= 8'hF0;
            ld1    <= JUNK;
        end else begin
            ld1 <= JUNK;
            case (bus1.Single_Instruction)
                INST_LB:  ld1 <= {{24{mem[ma][7]}}, mem[ma]};
                INST_LBU: ld1 <= {24'h0, mem[ma]};
                INST_LH:  ld1 <= {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
                INST_LHU: ld1 <= {16'h0, mem[ma+8'd1], mem[ma]};
                INST_LW:  ld1 <= {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
                INST_SB:  mem[ma] <= bus1.storeData[7:0];
                INST_SH:  begin
                    mem[ma]       <= bus1.storeData[7:0];
                    mem[ma+8'd1]  <= bus1.storeData[15:8];
                end
                INST_SW:  begin
                    mem[ma]       <= bus1.storeData[7:0];
                    mem[ma+8'd1]  <= bus1.storeData[15:8];
                    mem[ma+8'd2]  <= bus1.storeData[23:16];
                    mem[ma+8'd3]  <= bus1.storeData[31:24];
                end
                default: ;
            endcase
        end
    end

    // MEM_LAT=4 memory: data is valid only exactly 4 cycles after an issue
    logic [3:0] pipe4;
    always @(posedge clk) begin
        if (!reset4) pipe4 <= 4'b0;
        else         pipe4 <= {pipe4[2:0], (bus4.Single_Instruction != 64'd0)};
    end
    assign bus4.loadData_w = pipe4[3] ? 32'h1234_5678 : JUNK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One request on the MEM_LAT=1 instance, checked cycle by cycle until the response handshake
    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [63:0] esi, input logic [31:0] erd,
                        input logic eerr, input int elat, input int hold);
        int   k;
        bit   got;
        exp_t e;
        @(negedge clk);
        chk("idle_req_ready", 64'(bus1.req_ready), 64'd1);
        bus1.req_valid  = 1'b1;
        bus1.req_store  = st;
        bus1.req_funct3 = f3;
        bus1.req_addr   = a;
        bus1.req_wdata  = wd;
        sb_q.push_back({erd, eerr});
        k   = 0;
        got = 1'b0;
        while (!got && k < 16) begin
            @(negedge clk);
            k++;
            bus1.req_valid = 1'b0;
            chk("single_instruction", bus1.Single_Instruction, (k == 1) ? esi : 64'd0);
            if (k == 1 && esi != 64'd0) begin
                chk("issue_address", 64'(bus1.address), 64'(a));
                chk("issue_storeData", 64'(bus1.storeData), 64'(wd));
            end
            if (bus1.rsp_valid) got = 1'b1;
            else chk("busy_req_ready", 64'(bus1.req_ready), 64'd0);
        end
        chk("rsp_latency", 64'(k), 64'(elat));
        if (got) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty observed=%0d expected=nonzero", sb_q.size());
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 64'(bus1.rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(bus1.rsp_err), 64'(e.err));
                repeat (hold) begin
                    @(negedge clk);
                    chk("bp_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
                    chk("bp_rsp_rdata", 64'(bus1.rsp_rdata), 64'(e.rdata));
                    chk("bp_rsp_err", 64'(bus1.rsp_err), 64'(e.err));
                    chk("bp_req_ready", 64'(bus1.req_ready), 64'd0);
                    chk("bp_single_instruction", bus1.Single_Instruction, 64'd0);
                end
            end
            bus1.rsp_ready = 1'b1;
            @(negedge clk);
            bus1.rsp_ready = 1'b0;
            chk("post_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
            chk("post_req_ready", 64'(bus1.req_ready), 64'd1);
        end else begin
            sb_q.delete();
        end
    endtask

    initial begin
        int  k;
        bit  seen;
        reset1 = 1'b0;
        reset4 = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_store = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0; bus1.rsp_ready = 1'b0;
        bus4.req_valid = 1'b0; bus4.req_store = 1'b0; bus4.req_funct3 = 3'd0;
        bus4.req_addr  = 32'd0; bus4.req_wdata = 32'd0; bus4.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_req_ready", 64'(bus1.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus1.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bus1.rsp_err), 64'd0);
        chk("rst_single_instruction", bus1.Single_Instruction, 64'd0);
        chk("rst_address", 64'(bus1.address), 64'd0);
        chk("rst_storeData", 64'(bus1.storeData), 64'd0);
        reset1 = 1'b1;
        reset4 = 1'b1;

        // load after reset, store then load with backpressure, sub-word loads
        xact(1'b0, 3'd0, 32'h4, 32'h0,         INST_LB,  32'hFFFF_FFF0, 1'b0, 3, 0);
        xact(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, INST_SW,  32'h0,         1'b0, 2, 0);
        xact(1'b0, 3'd2, 32'h8, 32'h0,         INST_LW,  32'hDEAD_BEEF, 1'b0, 3, 5);
        xact(1'b0, 3'd1, 32'h8, 32'h0,         INST_LH,  32'hFFFF_BEEF, 1'b0, 3, 0);
        xact(1'b0, 3'd5, 32'hA, 32'h0,         INST_LHU, 32'h0000_DEAD, 1'b0, 3, 0);
        xact(1'b0, 3'd4, 32'h9, 32'h0,         INST_LBU, 32'h0000_00BE, 1'b0, 3, 0);

        // illegal funct3 never reaches dataMem
        xact(1'b0, 3'd3, 32'h8, 32'h0,         64'd0, 32'h0, 1'b1, 1, 2);
        xact(1'b0, 3'd6, 32'h8, 32'h0,         64'd0, 32'h0, 1'b1, 1, 0);
        xact(1'b0, 3'd7, 32'h8, 32'h0,         64'd0, 32'h0, 1'b1, 1, 0);
        xact(1'b1, 3'd3, 32'hC, 32'hFFFF_FFFF, 64'd0, 32'h0, 1'b1, 1, 0);

        // misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
        xact(1'b0, 3'd2, 32'h6, 32'h0, 64'd0,   32'h0,         1'b1, 1, 0);
`else
        xact(1'b0, 3'd2, 32'h6, 32'h0, INST_LW, 32'hBEEF_0000, 1'b0, 3, 0);
`endif

        // byte and halfword stores merged into one word
        xact(1'b1, 3'd0, 32'hC, 32'h1122_3377, INST_SB, 32'h0,         1'b0, 2, 0);
        xact(1'b1, 3'd1, 32'hE, 32'hAAAA_8001, INST_SH, 32'h0,         1'b0, 2, 0);
        xact(1'b0, 3'd2, 32'hC, 32'h0,         INST_LW, 32'h8001_0077, 1'b0, 3, 0);

        // MEM_LAT=4: full load latency
        @(negedge clk);
        chk("l4_idle_req_ready", 64'(bus4.req_ready), 64'd1);
        bus4.req_valid = 1'b1; bus4.req_store = 1'b0; bus4.req_funct3 = 3'd2;
        bus4.req_addr  = 32'h40; bus4.req_wdata = 32'h0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 16) begin
            @(negedge clk);
            k++;
            bus4.req_valid = 1'b0;
            if (bus4.rsp_valid) seen = 1'b1;
        end
        chk("l4_latency", 64'(k), 64'd6);
        chk("l4_rsp_rdata", 64'(bus4.rsp_rdata), 64'h1234_5678);
        chk("l4_rsp_err", 64'(bus4.rsp_err), 64'd0);
        bus4.rsp_ready = 1'b1;
        @(negedge clk);
        bus4.rsp_ready = 1'b0;

        // MEM_LAT=4: reset on the second WAIT cycle abandons the load
        bus4.req_valid = 1'b1; bus4.req_addr = 32'h44;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        chk("l4_issue_si", bus4.Single_Instruction, INST_LW);
        @(negedge clk);
        @(negedge clk);
        reset4 = 1'b0;
        @(negedge clk);
        reset4 = 1'b1;
        chk("mid_rst_req_ready", 64'(bus4.req_ready), 64'd1);
        chk("mid_rst_rsp_valid", 64'(bus4.rsp_valid), 64'd0);
        chk("mid_rst_rsp_rdata", 64'(bus4.rsp_rdata), 64'd0);
        chk("mid_rst_rsp_err", 64'(bus4.rsp_err), 64'd0);
        chk("mid_rst_single_instruction", bus4.Single_Instruction, 64'd0);
        chk("mid_rst_address", 64'(bus4.address), 64'd0);
        chk("mid_rst_storeData", 64'(bus4.storeData), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.rsp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_rsp_pulse", 64'(seen), 64'd0);
        chk("mid_rst_idle_ready", 64'(bus4.req_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Run-time bound in case a handshake never completes
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
